// File: rtl/asp_irq_responder_pkg.sv
// rtl/asp_irq_responder_pkg.sv - shared register offsets, source bits and FSM state for the ASP IRQ responder
package asp_irq_responder_pkg;

  localparam int ASP_IRQ_BIT_DMA_0  = 0;
  localparam int ASP_IRQ_BIT_KERNEL = 1;
  localparam int ASP_IRQ_BIT_DMA_1  = 2;

  localparam int ASP_IRQ_REG_STATUS     = 0;
  localparam int ASP_IRQ_REG_ENABLE     = 1;
  localparam int ASP_IRQ_REG_FORCE      = 2;
  localparam int ASP_IRQ_REG_IN_FLIGHT  = 3;
  localparam int ASP_IRQ_REG_COUNT_BASE = 4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } asp_irq_state_e;

endpackage

// File: rtl/asp_irq_rr_arb.sv
// rtl/asp_irq_rr_arb.sv - combinational round-robin find-first starting at a pointer
module asp_irq_rr_arb #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [$clog2(N)-1:0] grant_o,
  output logic                 any_o
);

  localparam int IDW = $clog2(N);

  int idx;

  // Scan from the farthest offset back to the pointer so the nearest request is written last.
  always_comb begin
    grant_o = '0;
    any_o   = 1'b0;
    idx     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr_i) + k) % N;
      if (req_i[idx]) begin
        grant_o = IDW'(idx);
        any_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/asp_irq_responder.sv
// rtl/asp_irq_responder.sv - edge-latched IRQ sources, round-robin host request issue, 64-bit CSR slave
module asp_irq_responder
  import asp_irq_responder_pkg::*;
#(
  parameter int NUM_IRQ_LINES  = 4,
  parameter int NUM_IRQ_USED   = 3,
  parameter int CSR_DATA_WIDTH = 64,
  parameter int CSR_ADDR_WIDTH = 3,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_IRQ_USED-1:0]          irq_src,
  input  logic [CSR_ADDR_WIDTH-1:0]        avs_address,
  input  logic                             avs_read,
  input  logic                             avs_write,
  input  logic [CSR_DATA_WIDTH-1:0]        avs_writedata,
  input  logic [CSR_DATA_WIDTH/8-1:0]      avs_byteenable,
  output logic [CSR_DATA_WIDTH-1:0]        avs_readdata,
  output logic                             avs_readdatavalid,
  output logic                             avs_waitrequest,
  output logic                             irq_req_valid,
  output logic [$clog2(NUM_IRQ_LINES)-1:0] irq_req_id,
  input  logic                             irq_req_ready,
  input  logic                             irq_ack_valid,
  input  logic [$clog2(NUM_IRQ_LINES)-1:0] irq_ack_id
);

  localparam int IDW = $clog2(NUM_IRQ_LINES);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NUM_IRQ_LINES - 1);

  logic [NUM_IRQ_USED-1:0]   src_q;
  logic [NUM_IRQ_LINES-1:0]  pending_q, pending_d, enable_q, enable_d, in_flight_q, in_flight_d;
  logic [COUNT_WIDTH-1:0]    cnt_q [NUM_IRQ_LINES];
  logic [COUNT_WIDTH-1:0]    cnt_d [NUM_IRQ_LINES];
  asp_irq_state_e            state_q, state_d;
  logic [IDW-1:0]            sel_q, sel_d, ptr_q, ptr_d;
  logic [CSR_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                      rvalid_q;

  logic [NUM_IRQ_LINES-1:0]  edge_v, eligible, dispatch, ack_mask, wr_bits, w1c, frc;
  logic [IDW-1:0]            grant;
  logic                      any_grant, handshake, wr_b0;
  logic [COUNT_WIDTH-1:0]    cnt_clr_mask;
  logic                      unused_csr_bits;

  assign edge_v   = NUM_IRQ_LINES'(irq_src & ~src_q);
  assign eligible = pending_q & enable_q & ~in_flight_q;
  assign wr_b0    = avs_write & avs_byteenable[0];
  assign wr_bits  = avs_writedata[NUM_IRQ_LINES-1:0];
  assign w1c      = (wr_b0 && avs_address == CSR_ADDR_WIDTH'(ASP_IRQ_REG_STATUS)) ? wr_bits : '0;
  assign frc      = (wr_b0 && avs_address == CSR_ADDR_WIDTH'(ASP_IRQ_REG_FORCE)) ? wr_bits : '0;
  assign avs_waitrequest   = 1'b0;
  assign avs_readdata      = rdata_q;
  assign avs_readdatavalid = rvalid_q;
  assign unused_csr_bits   = ^{avs_writedata, avs_byteenable};

  asp_irq_rr_arb #(.N(NUM_IRQ_LINES)) u_arb (
    .req_i   (eligible),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .any_o   (any_grant)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    dispatch  = '0;
    handshake = 1'b0;
    case (state_q)
      ST_IDLE: if (any_grant) begin
        sel_d           = grant;
        dispatch[grant] = 1'b1;
        state_d         = ST_REQ;
      end
      ST_REQ: if (irq_req_ready) begin
        handshake = 1'b1;
        ptr_d     = (sel_q == LAST_ID) ? '0 : sel_q + IDW'(1);
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    irq_req_valid = (state_q == ST_REQ);
    irq_req_id    = sel_q;
  end

  // Sets (edge, force) are ORed in last so they win over W1C and dispatch clears.
  always_comb begin
    ack_mask = '0;
    if (irq_ack_valid) ack_mask[irq_ack_id] = 1'b1;
    pending_d   = (pending_q & ~dispatch & ~w1c) | edge_v | frc;
    enable_d    = (wr_b0 && avs_address == CSR_ADDR_WIDTH'(ASP_IRQ_REG_ENABLE)) ? wr_bits : enable_q;
    in_flight_d = (in_flight_q & ~ack_mask) | dispatch;
  end

  always_comb begin
    cnt_clr_mask = '0;
    for (int j = 0; j < COUNT_WIDTH; j++) cnt_clr_mask[j] = avs_byteenable[j/8];
    for (int v = 0; v < NUM_IRQ_LINES; v++) begin
      cnt_d[v] = cnt_q[v];
      if (handshake && sel_q == IDW'(v) && cnt_q[v] != '1) cnt_d[v] = cnt_q[v] + COUNT_WIDTH'(1);
      if (avs_write && avs_address == CSR_ADDR_WIDTH'(ASP_IRQ_REG_COUNT_BASE + v))
        cnt_d[v] = cnt_d[v] & ~cnt_clr_mask;
    end
  end

  always_comb begin
    rdata_d = '0;
    if (avs_read) begin
      if (avs_address == CSR_ADDR_WIDTH'(ASP_IRQ_REG_STATUS))    rdata_d = CSR_DATA_WIDTH'(pending_q);
      if (avs_address == CSR_ADDR_WIDTH'(ASP_IRQ_REG_ENABLE))    rdata_d = CSR_DATA_WIDTH'(enable_q);
      if (avs_address == CSR_ADDR_WIDTH'(ASP_IRQ_REG_IN_FLIGHT)) rdata_d = CSR_DATA_WIDTH'(in_flight_q);
      for (int v = 0; v < NUM_IRQ_LINES; v++)
        if (avs_address == CSR_ADDR_WIDTH'(ASP_IRQ_REG_COUNT_BASE + v)) rdata_d = CSR_DATA_WIDTH'(cnt_q[v]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src_q       <= '0;
      pending_q   <= '0;
      enable_q    <= '0;
      in_flight_q <= '0;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
      for (int v = 0; v < NUM_IRQ_LINES; v++) cnt_q[v] <= '0;
    end else begin
      src_q       <= irq_src;
      pending_q   <= pending_d;
      enable_q    <= enable_d;
      in_flight_q <= in_flight_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= avs_read;
      for (int v = 0; v < NUM_IRQ_LINES; v++) cnt_q[v] <= cnt_d[v];
    end
  end

endmodule

// File: tb/tb_asp_irq_responder.sv
// tb/tb_asp_irq_responder.sv - directed self-checking bench for asp_irq_responder
module tb_asp_irq_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  irq_src = '0;
  logic [2:0]  avs_address = '0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [63:0] avs_writedata = '0;
  logic [7:0]  avs_byteenable = '0;
  logic [63:0] avs_readdata;
  logic        avs_readdatavalid;
  logic        avs_waitrequest;
  logic        irq_req_valid;
  logic [1:0]  irq_req_id;
  logic        irq_req_ready = 1'b1;
  logic        irq_ack_valid = 1'b0;
  logic [1:0]  irq_ack_id = '0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  asp_irq_responder dut (
    .clk               (clk),
    .reset             (reset),
    .irq_src           (irq_src),
    .avs_address       (avs_address),
    .avs_read          (avs_read),
    .avs_write         (avs_write),
    .avs_writedata     (avs_writedata),
    .avs_byteenable    (avs_byteenable),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .avs_waitrequest   (avs_waitrequest),
    .irq_req_valid     (irq_req_valid),
    .irq_req_id        (irq_req_id),
    .irq_req_ready     (irq_req_ready),
    .irq_ack_valid     (irq_ack_valid),
    .irq_ack_id        (irq_ack_id)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic csr_write(input logic [2:0] a, input logic [63:0] d);
    avs_address = a; avs_writedata = d; avs_byteenable = 8'hFF; avs_write = 1'b1;
    tick();
    avs_write = 1'b0;
  endtask

  task automatic csr_read(input logic [2:0] a, output logic [63:0] d, output logic v);
    avs_address = a; avs_read = 1'b1;
    tick();
    d = avs_readdata; v = avs_readdatavalid;
    avs_read = 1'b0;
  endtask

  task automatic pulse_src(input logic [2:0] bits);
    irq_src = bits;
    tick();
    irq_src = '0;
  endtask

  task automatic ack(input logic [1:0] id);
    irq_ack_valid = 1'b1; irq_ack_id = id;
    tick();
    irq_ack_valid = 1'b0;
  endtask

  task automatic wait_req(output logic got);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (irq_req_valid === 1'b1) got = 1'b1;
      else tick();
    end
  endtask

  task automatic count_reqs(input int n, output int seen);
    seen = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (irq_req_valid === 1'b1) seen++;
    end
  endtask

  task automatic test_reset();
    logic [63:0] d; logic v;
    tests++; if (irq_req_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0b expected 0", irq_req_valid); end
    tests++; if (irq_req_id !== 2'd0) begin fails++; $display("FAIL reset_id: got %0d expected 0", irq_req_id); end
    tests++; if (avs_readdatavalid !== 1'b0) begin fails++; $display("FAIL reset_rvalid: got %0b expected 0", avs_readdatavalid); end
    tests++; if (avs_readdata !== 64'h0) begin fails++; $display("FAIL reset_rdata: got %0h expected 0", avs_readdata); end
    tests++; if (avs_waitrequest !== 1'b0) begin fails++; $display("FAIL waitrequest: got %0b expected 0", avs_waitrequest); end
    csr_read(3'd1, d, v);
    tests++; if (d !== 64'h0) begin fails++; $display("FAIL reset_enable: got %0h expected 0", d); end
  endtask

  task automatic test_single();
    logic [63:0] d; logic v;
    irq_req_ready = 1'b1;
    csr_write(3'd1, 64'h7);
    irq_src = 3'b010;
    tick();
    irq_src = '0;
    tick();
    tests++; if (irq_req_valid !== 1'b1 || irq_req_id !== 2'd1) begin fails++; $display("FAIL single_req: got valid=%0b id=%0d expected valid=1 id=1", irq_req_valid, irq_req_id); end
    tick();
    tests++; if (irq_req_valid !== 1'b0) begin fails++; $display("FAIL single_one_cycle: got valid=%0b expected 0", irq_req_valid); end
    csr_read(3'd3, d, v);
    tests++; if (v !== 1'b1) begin fails++; $display("FAIL read_valid: got %0b expected 1", v); end
    tests++; if (d !== 64'h2) begin fails++; $display("FAIL single_inflight: got %0h expected 2", d); end
    csr_read(3'd5, d, v);
    tests++; if (d !== 64'h1) begin fails++; $display("FAIL single_count1: got %0h expected 1", d); end
    ack(2'd1);
    csr_read(3'd3, d, v);
    tests++; if (d !== 64'h0) begin fails++; $display("FAIL single_inflight_after_ack: got %0h expected 0", d); end
  endtask

  task automatic collect3(input logic [5:0] exp_ids, input string tag);
    logic got;
    for (int i = 0; i < 3; i++) begin
      wait_req(got);
      tests++;
      if (got !== 1'b1 || irq_req_id !== exp_ids[2*i +: 2]) begin
        fails++;
        $display("FAIL %s_req%0d: got valid=%0b id=%0d expected id=%0d", tag, i, got, irq_req_id, exp_ids[2*i +: 2]);
      end
      ack(irq_req_id);
    end
  endtask

  task automatic test_rr_order();
    logic got;
    do_reset();
    irq_req_ready = 1'b1;
    csr_write(3'd1, 64'h7);
    pulse_src(3'b111);
    collect3({2'd2, 2'd1, 2'd0}, "rr_ptr0");
    pulse_src(3'b001);
    wait_req(got);
    tests++; if (got !== 1'b1 || irq_req_id !== 2'd0) begin fails++; $display("FAIL rr_solo: got valid=%0b id=%0d expected id=0", got, irq_req_id); end
    ack(2'd0);
    pulse_src(3'b111);
    collect3({2'd0, 2'd2, 2'd1}, "rr_ptr1");
  endtask

  task automatic test_enable_gate();
    logic [63:0] d; logic v; logic got; int seen;
    csr_write(3'd1, 64'h0);
    pulse_src(3'b100);
    count_reqs(5, seen);
    tests++; if (seen !== 0) begin fails++; $display("FAIL gate_disabled: got %0d requests expected 0", seen); end
    csr_read(3'd0, d, v);
    tests++; if (d !== 64'h4) begin fails++; $display("FAIL gate_status: got %0h expected 4", d); end
    csr_write(3'd1, 64'h4);
    wait_req(got);
    tests++; if (got !== 1'b1 || irq_req_id !== 2'd2) begin fails++; $display("FAIL gate_enable_req: got valid=%0b id=%0d expected id=2", got, irq_req_id); end
    ack(2'd2);
    csr_write(3'd1, 64'h0);
    pulse_src(3'b100);
    csr_write(3'd0, 64'h4);
    csr_write(3'd1, 64'h4);
    count_reqs(5, seen);
    tests++; if (seen !== 0) begin fails++; $display("FAIL gate_w1c: got %0d requests expected 0", seen); end
    csr_read(3'd0, d, v);
    tests++; if (d !== 64'h0) begin fails++; $display("FAIL gate_status_cleared: got %0h expected 0", d); end
  endtask

  task automatic test_csr_misc();
    logic [63:0] d; logic v;
    avs_address = 3'd1; avs_writedata = 64'hF5; avs_byteenable = 8'hFF;
    avs_read = 1'b1; avs_write = 1'b1;
    tick();
    d = avs_readdata;
    avs_read = 1'b0; avs_write = 1'b0;
    tests++; if (d !== 64'h4) begin fails++; $display("FAIL rw_same_pre: got %0h expected 4", d); end
    csr_read(3'd1, d, v);
    tests++; if (d !== 64'h5) begin fails++; $display("FAIL enable_upper_ignored: got %0h expected 5", d); end
    csr_read(3'd5, d, v);
    tests++; if (d !== 64'h2) begin fails++; $display("FAIL count1: got %0h expected 2", d); end
    csr_write(3'd6, 64'hDEAD);
    csr_read(3'd6, d, v);
    tests++; if (d !== 64'h0) begin fails++; $display("FAIL count2_clear: got %0h expected 0", d); end
    csr_read(3'd2, d, v);
    tests++; if (d !== 64'h0) begin fails++; $display("FAIL force_reads0: got %0h expected 0", d); end
  endtask

  task automatic test_ready_stall();
    logic [63:0] d; logic v; logic got;
    csr_write(3'd1, 64'h7);
    irq_req_ready = 1'b0;
    pulse_src(3'b001);
    wait_req(got);
    tests++; if (got !== 1'b1 || irq_req_id !== 2'd0) begin fails++; $display("FAIL stall_req: got valid=%0b id=%0d expected id=0", got, irq_req_id); end
    for (int i = 0; i < 5; i++) begin
      tick();
      tests++;
      if (irq_req_valid !== 1'b1 || irq_req_id !== 2'd0) begin
        fails++; $display("FAIL stall_hold%0d: got valid=%0b id=%0d expected valid=1 id=0", i, irq_req_valid, irq_req_id);
      end
    end
    csr_read(3'd4, d, v);
    tests++; if (d !== 64'h3) begin fails++; $display("FAIL stall_count_unchanged: got %0h expected 3", d); end
    irq_req_ready = 1'b1;
    tick();
    tests++; if (irq_req_valid !== 1'b0) begin fails++; $display("FAIL stall_release: got valid=%0b expected 0", irq_req_valid); end
    csr_read(3'd4, d, v);
    tests++; if (d !== 64'h4) begin fails++; $display("FAIL stall_count_after: got %0h expected 4", d); end
    ack(2'd0);
  endtask

  task automatic test_inflight_block();
    logic [63:0] d; logic v; logic got; int seen;
    pulse_src(3'b001);
    wait_req(got);
    tests++; if (got !== 1'b1 || irq_req_id !== 2'd0) begin fails++; $display("FAIL block_first: got valid=%0b id=%0d expected id=0", got, irq_req_id); end
    tick();
    pulse_src(3'b001);
    count_reqs(5, seen);
    tests++; if (seen !== 0) begin fails++; $display("FAIL block_no_second: got %0d requests expected 0", seen); end
    csr_read(3'd0, d, v);
    tests++; if (d !== 64'h1) begin fails++; $display("FAIL block_pending: got %0h expected 1", d); end
    csr_read(3'd3, d, v);
    tests++; if (d !== 64'h1) begin fails++; $display("FAIL block_inflight: got %0h expected 1", d); end
    ack(2'd0);
    wait_req(got);
    tests++; if (got !== 1'b1 || irq_req_id !== 2'd0) begin fails++; $display("FAIL block_after_ack: got valid=%0b id=%0d expected id=0", got, irq_req_id); end
    ack(2'd0);
    count_reqs(6, seen);
    tests++; if (seen !== 0) begin fails++; $display("FAIL block_exactly_one: got %0d extra requests expected 0", seen); end
    csr_read(3'd4, d, v);
    tests++; if (d !== 64'h6) begin fails++; $display("FAIL block_count: got %0h expected 6", d); end
  endtask

  task automatic test_force_reset();
    logic [63:0] d; logic v; logic got;
    csr_write(3'd1, 64'h8);
    irq_req_ready = 1'b0;
    csr_write(3'd2, 64'h8);
    wait_req(got);
    tests++; if (got !== 1'b1 || irq_req_id !== 2'd3) begin fails++; $display("FAIL force_req: got valid=%0b id=%0d expected id=3", got, irq_req_id); end
    csr_read(3'd3, d, v);
    tests++; if (d !== 64'h8) begin fails++; $display("FAIL force_inflight: got %0h expected 8", d); end
    reset = 1'b1;
    #1;
    tests++; if (irq_req_valid !== 1'b0) begin fails++; $display("FAIL reset_drops_req: got valid=%0b expected 0", irq_req_valid); end
    tick();
    tick();
    reset = 1'b0;
    for (int a = 0; a < 8; a++) begin
      csr_read(3'(a), d, v);
      tests++; if (d !== 64'h0) begin fails++; $display("FAIL post_reset_reg%0d: got %0h expected 0", a, d); end
    end
    tests++; if (irq_req_valid !== 1'b0) begin fails++; $display("FAIL post_reset_valid: got %0b expected 0", irq_req_valid); end
  endtask

  initial begin
    tick();
    tick();
    reset = 1'b0;
    test_reset();
    test_single();
    test_rr_order();
    test_enable_gate();
    test_csr_misc();
    test_ready_stall();
    test_inflight_block();
    test_force_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
